// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One digit per PRESCALE-cycle slot, with blanking at slot start, leading-zero suppression and frame sync.
module sseg_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 4,
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int IDX_W    = $clog2(N_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_blank,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              sseg,
  output logic                    frame_tick,
  output logic [IDX_W-1:0]        dbg_idx,
  output logic [CNT_W-1:0]        dbg_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;
  logic                  ft_q, ft_d;

  logic [3:0]            digit_sel;
  logic                  dp_sel;
  logic                  suppress;
  logic                  zero_above;
  logic [N_DIGITS-1:0]   lz_mask;

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan position: disabled scanning parks at slot 0 so re-enable starts with a full blank interval.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    ft_d  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      ft_d  = (idx_q == LAST_IDX);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Whole-vector capture keeps every digit consistent within one frame.
  always_comb begin
    hex_d = load ? hex_in : hex_q;
    dp_d  = load ? dp_in  : dp_q;
  end

  // lz_mask[k] is set when digit k and every digit above it are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (hex_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  always_comb begin
    digit_sel = 4'h0;
    dp_sel    = 1'b0;
    suppress  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit_sel = hex_q[4*k +: 4];
        dp_sel    = dp_q[k];
        suppress  = lz_blank && (k != 0) && lz_mask[k];
      end
    end
  end

  always_comb begin
    an_d   = '1;
    sseg_d = 8'hFF;
    if (en && !(cnt_q < BLANK_V)) begin
      an_d   = ~(N_DIGITS'(1) << idx_q);
      sseg_d = {~dp_sel, suppress ? 7'h7F : decode(digit_sel)};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      hex_q  <= '0;
      dp_q   <= '0;
      an_q   <= '1;
      sseg_q <= 8'hFF;
      ft_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      hex_q  <= hex_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      ft_q   <= ft_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = ft_q;
  assign dbg_idx    = idx_q;
  assign dbg_cnt    = cnt_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed plus randomized bench for sseg_scan_ctrl; a cycle-time model predicts every output.
module tb_sseg_scan_ctrl;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  hex_in = '0;
  logic [3:0]   dp_in = '0;
  logic         lz_blank = 1'b0;
  logic [3:0]   an;
  logic [7:0]   sseg;
  logic         frame_tick;
  logic [1:0]   dbg_idx;
  logic [2:0]   dbg_cnt;

  int n_pass = 0;
  int n_total = 0;

  // Model: elapsed enabled cycles since scan start, plus the shadow contents.
  int          m_t = 0;
  logic [15:0] m_hex = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  e_an = 4'hF;
  logic [7:0]  e_sseg = 8'hFF;
  logic        e_ft = 1'b0;
  logic [7:0]  seg_tab [16];
  int          ft_seen;

  sseg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .hex_in(hex_in),
    .dp_in(dp_in), .lz_blank(lz_blank), .an(an), .sseg(sseg),
    .frame_tick(frame_tick), .dbg_idx(dbg_idx), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Output for the pre-edge model state, then advance the model by one edge.
  task automatic model_step();
    int slot, phase, d;
    logic all_zero;
    slot  = (m_t / P) % N;
    phase = m_t % P;
    e_an = 4'hF; e_sseg = 8'hFF; e_ft = 1'b0;
    if (en && phase >= B) begin
      d = (m_hex >> (4 * slot)) & 16'hF;
      all_zero = ((m_hex >> (4 * slot)) == 16'h0);
      e_an = 4'hF & ~(4'(1) << slot);
      e_sseg = seg_tab[d];
      if (lz_blank && slot > 0 && all_zero) e_sseg = 8'h7F;
      e_sseg[7] = ~m_dp[slot];
    end
    if (en && phase == P - 1 && slot == N - 1) e_ft = 1'b1;
    m_t = en ? m_t + 1 : 0;
    if (load) begin m_hex = hex_in; m_dp = dp_in; end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".an"}, 32'(an), 32'(e_an));
    check({tag, ".sseg"}, 32'(sseg), 32'(e_sseg));
    check({tag, ".ft"}, 32'(frame_tick), 32'(e_ft));
    check({tag, ".idx"}, 32'(dbg_idx), 32'((m_t / P) % N));
    check({tag, ".cnt"}, 32'(dbg_cnt), 32'(m_t % P));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (frame_tick) ft_seen++;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    seg_tab[0]  = 8'h81; seg_tab[1]  = 8'hCF; seg_tab[2]  = 8'h92; seg_tab[3]  = 8'h86;
    seg_tab[4]  = 8'hCC; seg_tab[5]  = 8'hA4; seg_tab[6]  = 8'hA0; seg_tab[7]  = 8'h8F;
    seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h84; seg_tab[10] = 8'h88; seg_tab[11] = 8'hE0;
    seg_tab[12] = 8'hB1; seg_tab[13] = 8'hC2; seg_tab[14] = 8'hB0; seg_tab[15] = 8'hB8;

    // Reset state
    @(negedge clk);
    check("rst.an", 32'(an), 32'hF);
    check("rst.sseg", 32'(sseg), 32'hFF);
    check("rst.ft", 32'(frame_tick), 32'h0);
    check("rst.idx", 32'(dbg_idx), 32'h0);
    check("rst.cnt", 32'(dbg_cnt), 32'h0);
    reset_n = 1'b1;
    en = 1'b1;

    // Scan of all-zero shadow, explicit first-slot values plus frame rate
    tick("blank0"); check("blank0.an_lit", 32'(an), 32'hF);
    tick("blank1"); check("blank1.sseg_lit", 32'(sseg), 32'hFF);
    tick("dig0"); check("dig0.an_lit", 32'(an), 32'hE); check("dig0.sseg_lit", 32'(sseg), 32'h81);
    ft_seen = 0;
    run("zero_scan", 64);
    check("frame_count", 32'(ft_seen), 32'd2);

    // Mixed digits with one decimal point
    hex_in = 16'h12EF; dp_in = 4'b0100; load = 1'b1;
    tick("load1"); load = 1'b0;
    run("scan_12EF", 40);

    // Leading-zero suppression on and off
    hex_in = 16'h0050; dp_in = 4'b0000; load = 1'b1; lz_blank = 1'b1;
    tick("load2"); load = 1'b0;
    run("lz_on", 36);
    lz_blank = 1'b0;
    run("lz_off", 36);

    // en dropped at cnt=5 of digit 2, then re-enabled
    en = 1'b0; tick("park");
    en = 1'b1;
    run("to_d2c5", 2 * P + 5);
    en = 1'b0; tick("en_drop");
    check("en_drop.an_lit", 32'(an), 32'hF);
    check("en_drop.idx_lit", 32'(dbg_idx), 32'h0);
    check("en_drop.cnt_lit", 32'(dbg_cnt), 32'h0);
    hex_in = 16'hA7C3; dp_in = 4'b0011; load = 1'b1;
    tick("load_en0"); load = 1'b0;
    en = 1'b1;
    run("reenable", 12);

    // Randomized stimulus
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 7) == 0);
      hex_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1) hex_in = hex_in & (16'hFFFF >> (4 * $urandom_range(1, 3)));
      dp_in = 4'($urandom);
      lz_blank = 1'($urandom);
      tick("rand");
    end
    load = 1'b0; en = 1'b1;
    run("settle", 10);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("async.an", 32'(an), 32'hF);
    check("async.sseg", 32'(sseg), 32'hFF);
    check("async.ft", 32'(frame_tick), 32'h0);
    m_t = 0; m_hex = '0; m_dp = '0;
    @(posedge clk); @(negedge clk);
    check("async_hold.an", 32'(an), 32'hF);
    check("async_hold.ft", 32'(frame_tick), 32'h0);
    reset_n = 1'b1;
    lz_blank = 1'b0;
    run("post_rst", 40);

    // Load on the same edge as the wrap to digit 0
    hex_in = 16'h3C9B; dp_in = 4'b0001;
    while ((m_t % (P * N)) != P * N - 1) tick("to_wrap");
    load = 1'b1;
    tick("wrap_load"); load = 1'b0;
    check("wrap_load.ft_lit", 32'(frame_tick), 32'h1);
    run("after_wrap", P);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode N-digit seven-segment display.
- Holds a shadow copy of N hex digits plus decimal points and selects one digit per time slot.
- Decodes the selected digit to active-low segments and drives one active-low anode at a time.
- Adds an inter-digit blanking interval against ghosting, optional leading-zero suppression, and a frame-sync pulse.
- Sits between the system logic producing hex values and the board display pins.

Parameters:
- N_DIGITS, 4: number of digits scanned; legal range 2..8.
- PRESCALE, 50000: clock cycles per digit slot; must be >= BLANK_CYC+1.
- BLANK_CYC, 4: cycles at the start of each slot with all anodes off; 0 disables blanking.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = scanning; 0 = display dark and scan state held at slot start.
- load  in  1  capture strobe for hex_in/dp_in.
- hex_in  in  4*N_DIGITS  digit k occupies bits [4k+3:4k]; digit 0 is rightmost.
- dp_in  in  N_DIGITS  1 = decimal point lit for digit k.
- lz_blank  in  1  1 = suppress leading zeros.
- an  out  N_DIGITS  anode enables, active low, at most one bit low.
- sseg  out  8  segments, active low: [7]=dp, [6:0]={a,b,c,d,e,f,g}.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0.

Behaviour:
- Reset (async assert, synchronous release on clk): idx=0, cnt=0, shadow hex=0, shadow dp=0.
  - Outputs at reset: an=all 1, sseg=8'hFF, frame_tick=0.
- Shadow capture: at an edge with load=1, the shadow takes hex_in and dp_in.
  - The new value is seen on sseg/an at the next edge (one-cycle latency from capture).
  - A digit is never shown half-updated: the capture is atomic across all digits.
- Scan counter cnt (width clog2(PRESCALE)): increments every cycle while en=1.
  - At cnt=PRESCALE-1: cnt becomes 0 and idx becomes (idx+1) mod N_DIGITS.
  - On the edge where idx wraps N_DIGITS-1 -> 0, frame_tick is 1 for exactly that one cycle.
- Output registers update every edge from the current (idx, cnt, shadow):
  - en=0 or cnt<BLANK_CYC: an=all 1, sseg=8'hFF.
  - Otherwise: an = all 1 except bit idx = 0; sseg[6:0] = decode(shadow digit idx); sseg[7] = ~dp[idx].
- Decode table (hex digit -> {a..g}, 0 = segment on):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression (lz_blank=1):
  - Digit k>0 is blanked when it and every digit above it are 0: sseg[6:0]=7'h7F.
  - Its anode is still driven; dp still follows dp[k].
  - Digit 0 is never suppressed.
- en deassert mid-slot:
  - At the next edge: idx=0, cnt=0, an=all 1, sseg=8'hFF, frame_tick=0.
  - Scanning restarts from digit 0 with a full blanking interval when en returns to 1.
- Simultaneous events:
  - load during a slot takes effect from the next edge, even mid-slot.
  - load while en=0 still updates the shadow.
  - A wrap and a load on the same edge are both applied.
- Reset mid-operation: immediate dark display, shadow cleared; no frame_tick is emitted.

Test Plan:
- Test parameters: N_DIGITS=4, PRESCALE=8, BLANK_CYC=2.
- Reset release, en=1, no load:
  - First 2 cycles: an=4'b1111, sseg=8'hFF.
  - Then 6 cycles: an=4'b1110, sseg=8'h81.
  - Then digit 1 follows, and frame_tick pulses once every 32 cycles.
- load with hex_in=16'h12EF, dp_in=4'b0100, lz_blank=0:
  - Digit 0 shows sseg=8'hB8 (F), digit 1 shows 8'hB0 (E).
  - Digit 2 shows 8'h4F (1 with dp lit), digit 3 shows 8'h92 (2).
- hex_in=16'h0050, lz_blank=1:
  - Digits 3 and 2 show sseg=8'hFF with their anode low.
  - Digit 1 shows 8'hA4, digit 0 shows 8'h81.
  - With lz_blank=0, digits 3 and 2 show 8'h81.
- en dropped at cnt=5 of digit 2:
  - Next edge: an=4'b1111; idx and cnt read 0.
  - On re-enable, 2 blank cycles, then an=4'b1110.
- reset_n pulsed low asynchronously mid-slot between edges:
  - an=4'b1111 and sseg=8'hFF immediately.
  - Shadow reads 0 after release; frame_tick stays 0.
- load asserted on the same edge as the wrap to digit 0:
  - frame_tick=1 for that cycle.
  - Digit 0's first non-blank cycle shows the newly loaded value.
